imem_responder: RTL and testbench

Instruction-memory responder serving the processor datapath's fetch interface (`imemreq_val`, `imemreq_addr`, `imemresp_data`). It holds a word-addressed program store that the bench loads through a dedicated write port. Each valid fetch request is answered after a fixed, parameterized latency through a response pipeline. A serviced-request counter and optional address-error reporting are included. It sits beside the processor in the top-level test harness as the far end of the fetch stage.

---
 rtl/imem_responder.sv | 131 +++++++++++++
 tb/tb_imem_responder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed program store with a fixed-latency fetch pipeline.
// Define IMEM_ERR_EN to compile in misaligned / out-of-range fetch error reporting.
module imem_responder #(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        imem_err,
  output logic        err_sticky,
  output logic [15:0] req_count
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  logic [31:0]      mem_q [NUM_WORDS];
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] load_idx;
  logic [31:0]      rd_word;
  logic             req_err;
  logic [31:0]      req_data;
  logic [15:0]      req_count_q;
  logic [15:0]      req_count_d;

  assign req_idx  = imemreq_addr[IDX_W+1:2];
  assign load_idx = load_addr[IDX_W+1:2];
  assign rd_word  = mem_q[req_idx];

  // Store is never reset; the read above sees the pre-edge contents, so a
  // same-cycle load to the fetched word is only visible to later fetches.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
  end

`ifdef IMEM_ERR_EN
  logic unused_load_bits;
  assign unused_load_bits = ^{load_addr[31:IDX_W+2], load_addr[1:0]};
  assign req_err = imemreq_val &&
                   ((imemreq_addr[1:0] != 2'b00) || (imemreq_addr >= 32'(4 * NUM_WORDS)));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{load_addr[31:IDX_W+2], load_addr[1:0],
                              imemreq_addr[31:IDX_W+2], imemreq_addr[1:0]};
  assign req_err = 1'b0;
`endif

  assign req_data = (imemreq_val && !req_err) ? rd_word : 32'h0;

  generate
    if (LATENCY == 0) begin : g_comb
      assign imemresp_val  = imemreq_val;
      assign imemresp_data = req_data;
      assign imem_err      = req_err;
    end else begin : g_pipe
      for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic        val_q;
        logic [31:0] data_q;
        logic        err_q;
        if (s == 0) begin : g_first
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              val_q  <= 1'b0;
              data_q <= 32'h0;
              err_q  <= 1'b0;
            end else begin
              val_q  <= imemreq_val;
              data_q <= req_data;
              err_q  <= req_err;
            end
          end
        end else begin : g_next
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              val_q  <= 1'b0;
              data_q <= 32'h0;
              err_q  <= 1'b0;
            end else begin
              val_q  <= g_stage[s-1].val_q;
              data_q <= g_stage[s-1].data_q;
              err_q  <= g_stage[s-1].err_q;
            end
          end
        end
      end
      assign imemresp_val  = g_stage[LATENCY-1].val_q;
      assign imemresp_data = g_stage[LATENCY-1].val_q ? g_stage[LATENCY-1].data_q : 32'h0;
      assign imem_err      = g_stage[LATENCY-1].val_q & g_stage[LATENCY-1].err_q;
    end
  endgenerate

  assign req_count_d = imemreq_val ? req_count_q + 16'd1 : req_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_count_q <= 16'h0;
    end else begin
      req_count_q <= req_count_d;
    end
  end

  assign req_count = req_count_q;

`ifdef IMEM_ERR_EN
  logic sticky_q;
  logic sticky_d;

  // The flag is visible in the same cycle as the first error response.
  assign sticky_d   = sticky_q | (imemresp_val & imem_err);
  assign err_sticky = sticky_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four instances (LATENCY 0..3) share stimulus and are compared
// against a per-cycle request history model; honours IMEM_ERR_EN when defined.
`timescale 1ns/1ps
module tb_imem_responder;

  localparam int NW = 256;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic [31:0] req_addr;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  logic        r_val    [ND];
  logic [31:0] r_data   [ND];
  logic        r_err    [ND];
  logic        r_sticky [ND];
  logic [15:0] r_cnt    [ND];

  always #5 clk = ~clk;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    imem_responder #(.NUM_WORDS(NW), .LATENCY(k)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .imemreq_val   (req_val),
      .imemreq_addr  (req_addr),
      .imemresp_val  (r_val[k]),
      .imemresp_data (r_data[k]),
      .load_en       (ld_en),
      .load_addr     (ld_addr),
      .load_data     (ld_data),
      .imem_err      (r_err[k]),
      .err_sticky    (r_sticky[k]),
      .req_count     (r_cnt[k])
    );
  end

  // Reference model: ideal store plus a history of what each cycle's request should return.
  logic [31:0] mmem [NW];
  logic        ring_val  [8];
  logic [31:0] ring_data [8];
  logic        ring_err  [8];
  logic [15:0] m_cnt;
  logic        m_sticky [ND];
  int          t;
  logic [50:0] exp_v [ND];
  logic [50:0] obs_v [ND];
  int          n_chk;
  int          n_err;

  always_comb begin
    for (int k = 0; k < ND; k++) begin
      obs_v[k] = {r_val[k], r_data[k], r_err[k], r_sticky[k], r_cnt[k]};
    end
  end

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef IMEM_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'(4 * NW));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(NW));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ring_val[i] = 1'b0;
    for (int k = 0; k < ND; k++) m_sticky[k] = 1'b0;
    m_cnt = 16'h0;
  endtask

  // Drive one cycle's inputs, work out every instance's expected outputs, wait to mid-cycle.
  task automatic drive(input logic v, input logic [31:0] a, input logic le,
                       input logic [31:0] la, input logic [31:0] ld);
    logic        bad;
    logic [31:0] cur_d;
    logic        e_v, e_e;
    logic [31:0] e_d;
    int          s;
    req_val = v; req_addr = a; ld_en = le; ld_addr = la; ld_data = ld;
    bad   = v && addr_bad(a);
    cur_d = (v && !bad) ? mmem[widx(a)] : 32'h0;
    ring_val[t & 7]  = v && rst;
    ring_err[t & 7]  = bad;
    ring_data[t & 7] = cur_d;
    for (int k = 0; k < ND; k++) begin
      if (k == 0) begin
        e_v = v; e_e = bad; e_d = cur_d;
      end else begin
        s   = (t - k) & 7;
        e_v = ring_val[s];
        e_e = ring_val[s] & ring_err[s];
        e_d = ring_val[s] ? ring_data[s] : 32'h0;
      end
      exp_v[k] = {e_v, e_d, e_e, m_sticky[k] | (e_v & e_e), m_cnt};
    end
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (ld_en) mmem[widx(ld_addr)] = ld_data;
    if (rst) begin
      if (req_val) m_cnt = m_cnt + 16'd1;
      for (int k = 0; k < ND; k++) m_sticky[k] = m_sticky[k] | (exp_v[k][50] & exp_v[k][17]);
    end
    t++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    advance();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_val = 1'b0; req_addr = 32'h0; ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      n_chk++;
      if (obs_v[k] !== 51'h0) begin
        n_err++;
        $display("FAIL reset_values L%0d got %h expected 0", k, obs_v[k]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_load_program();
    logic [31:0] d;
    for (int i = 0; i < NW; i++) begin
      d = (i == 0) ? 32'h00000013 : (i == 1) ? 32'h00500093 : (i == 2) ? 32'h11111111 : $urandom;
      drive(1'b0, 32'h0, 1'b1, 32'(i * 4), d);
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL load_idle L%0d t=%0d got %h expected %h", k, t, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_fetch_l0();
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    n_chk++;
    if (r_val[0] !== 1'b1 || r_data[0] !== 32'h00500093) begin
      n_err++;
      $display("FAIL fetch_l0 got val=%b data=%h expected val=1 data=00500093", r_val[0], r_data[0]);
    end
    for (int k = 0; k < ND; k++) begin
      n_chk++;
      if (obs_v[k] !== exp_v[k]) begin
        n_err++;
        $display("FAIL fetch_l0_model L%0d got %h expected %h", k, obs_v[k], exp_v[k]);
      end
    end
    advance();
  endtask

  task automatic test_pipelined();
    logic [31:0] addrs [6];
    logic [31:0] want  [6];
    addrs = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0};
    want  = '{32'h0, 32'h0, 32'h00000013, 32'h00500093, 32'h00000013, 32'h0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, addrs[i], 1'b0, 32'h0, 32'h0);
      n_chk++;
      if (r_val[2] !== (i >= 2 && i <= 4) || r_data[2] !== want[i]) begin
        n_err++;
        $display("FAIL pipelined_l2 cycle %0d got val=%b data=%h expected data=%h",
                 i, r_val[2], r_data[2], want[i]);
      end
      if (i >= 3) begin
        n_chk++;
        if (r_cnt[2] !== 16'd3) begin
          n_err++;
          $display("FAIL pipelined_count got %0d expected 3", r_cnt[2]);
        end
      end
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL pipelined_model L%0d cycle %0d got %h expected %h", k, i, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 32'h8, i == 0, 32'h8, 32'hDEADBEEF);
      if (i == 0) begin
        n_chk++;
        if (r_data[0] !== 32'h11111111) begin
          n_err++;
          $display("FAIL collision_l0_old got %h expected 11111111", r_data[0]);
        end
      end
      if (i == 1 || i == 2) begin
        n_chk++;
        if (r_val[1] !== 1'b1 || r_data[1] !== ((i == 1) ? 32'h11111111 : 32'hDEADBEEF)) begin
          n_err++;
          $display("FAIL collision_l1 cycle %0d got val=%b data=%h", i, r_val[1], r_data[1]);
        end
      end
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL collision_model L%0d cycle %0d got %h expected %h", k, i, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL midflight_issue L%0d got %h expected %h", k, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
    req_val = 1'b0; ld_en = 1'b0;
    #1;
    n_chk++;
    if (r_val[1] !== 1'b1 || r_val[2] !== 1'b1) begin
      n_err++;
      $display("FAIL midflight_pre got val1=%b val2=%b expected 1 1", r_val[1], r_val[2]);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (r_val[1] !== 1'b0 || r_val[2] !== 1'b0 || r_val[3] !== 1'b0 || r_cnt[3] !== 16'h0) begin
      n_err++;
      $display("FAIL midflight_drop got val=%b%b%b cnt=%0d expected 000 cnt=0",
               r_val[1], r_val[2], r_val[3], r_cnt[3]);
    end
    model_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 2) rst = 1'b1;
      drive(i == 5, 32'h4, 1'b0, 32'h0, 32'h0);
      if (i == 8) begin
        n_chk++;
        if (r_val[3] !== 1'b1 || r_data[3] !== 32'h00500093) begin
          n_err++;
          $display("FAIL midflight_store got val=%b data=%h expected 00500093", r_val[3], r_data[3]);
        end
      end
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL midflight_after L%0d cycle %0d got %h expected %h", k, i, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_error();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, (i == 0) ? 32'h2 : 32'h400, 1'b0, 32'h0, 32'h0);
      if (i == 1 || i == 2) begin
        n_chk++;
`ifdef IMEM_ERR_EN
        if (r_val[1] !== 1'b1 || r_data[1] !== 32'h0 || r_err[1] !== 1'b1) begin
          n_err++;
          $display("FAIL error_resp cycle %0d got val=%b data=%h err=%b expected 1 0 1",
                   i, r_val[1], r_data[1], r_err[1]);
        end
`else
        if (r_val[1] !== 1'b1 || r_data[1] !== 32'h00000013 || r_err[1] !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_resp cycle %0d got val=%b data=%h err=%b expected 1 00000013 0",
                   i, r_val[1], r_data[1], r_err[1]);
        end
`endif
      end
      if (i == 3) begin
        n_chk++;
`ifdef IMEM_ERR_EN
        if (r_sticky[1] !== 1'b1) begin
`else
        if (r_sticky[1] !== 1'b0) begin
`endif
          n_err++;
          $display("FAIL error_sticky got %b", r_sticky[1]);
        end
      end
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL error_model L%0d cycle %0d got %h expected %h", k, i, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic        v, le;
    logic [31:0] a, la;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      case ($urandom % 8)
        0:       a = ($urandom % 32'(4 * NW)) | 32'(1 + $urandom % 3);
        1:       a = 32'(4 * NW) + ($urandom % 32'h10000);
        default: a = ($urandom % 32'(NW)) << 2;
      endcase
      le = ($urandom % 4) == 0;
      la = ($urandom % 2) ? a : (($urandom % 32'(NW)) << 2);
      drive(v, a, le, la, $urandom);
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL random L%0d t=%0d got %h expected %h", k, t, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, ($urandom % 32'(NW)) << 2, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < ND; k++) begin
        n_chk++;
        if (obs_v[k] !== exp_v[k]) begin
          n_err++;
          $display("FAIL wrap_model L%0d i=%0d got %h expected %h", k, i, obs_v[k], exp_v[k]);
        end
      end
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < ND; k++) begin
      n_chk++;
      if (r_cnt[k] !== 16'h0) begin
        n_err++;
        $display("FAIL counter_wrap L%0d got %h expected 0000", k, r_cnt[k]);
      end
    end
    advance();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    t = 8;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      ring_data[i] = 32'h0;
      ring_err[i]  = 1'b0;
    end
    test_reset();
    test_load_program();
    test_fetch_l0();
    test_pipelined();
    test_collision();
    test_reset_midflight();
    test_error();
    test_random();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at t=%0d", t);
    $fatal(1, "watchdog");
  end

endmodule
